// File: rtl/mem_access_sequencer.sv
// Control-unit-side initiator for the RAM MOV/MOC four-phase handshake.
// Checks access alignment, drives MOV/RW/type, and waits for MOC or gives up after TIMEOUT.
module mem_access_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int ADDR_W  = 9
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_req,
  input  logic              i_req_rw,
  input  logic [1:0]        i_req_type,
  input  logic              i_req_dest,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic              i_moc,
  output logic              o_mov,
  output logic              o_rw,
  output logic [1:0]        o_type,
  output logic              o_ir_ld,
  output logic              o_mdr_ld,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_align_err,
  output logic              o_timeout,
  output logic [1:0]        o_state
);

  // Handshake toward RAM: MOV rises with acceptance and stays up (with RW/type
  // stable) until MOC is seen or the wait expires; MOC must then drop before
  // the sequencer returns to IDLE, so a new MOV never overlaps an old MOC.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_dest, w_dest_nxt;
  logic        r_mov, w_mov_nxt;
  logic        r_rw, w_rw_nxt;
  logic [1:0]  r_type, w_type_nxt;
  logic        r_ir_ld, w_ir_ld_nxt;
  logic        r_mdr_ld, w_mdr_ld_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic        r_align_err, w_align_err_nxt;
  logic        r_timeout, w_timeout_nxt;
  logic        w_misaligned;

  always_comb begin
    w_misaligned = (i_req_type == 2'b11)
                || ((i_req_type == 2'b01) && ((i_req_addr & ADDR_W'(1)) != '0))
                || ((i_req_type == 2'b10) && ((i_req_addr & ADDR_W'(3)) != '0));
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_dest_nxt      = r_dest;
    w_mov_nxt       = r_mov;
    w_rw_nxt        = r_rw;
    w_type_nxt      = r_type;
    w_ir_ld_nxt     = 1'b0;
    w_mdr_ld_nxt    = 1'b0;
    w_done_nxt      = 1'b0;
    w_align_err_nxt = 1'b0;
    w_timeout_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req) begin
          if (w_misaligned) begin
            w_align_err_nxt = 1'b1;
          end else begin
            w_mov_nxt   = 1'b1;
            w_rw_nxt    = i_req_rw;
            w_type_nxt  = i_req_type;
            w_dest_nxt  = i_req_dest;
            w_cnt_nxt   = 8'd0;
            w_state_nxt = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        // MOC wins over the expiry check when both land on the same edge.
        if (i_moc) begin
          w_mov_nxt    = 1'b0;
          w_done_nxt   = 1'b1;
          w_ir_ld_nxt  = r_rw & r_dest;
          w_mdr_ld_nxt = r_rw & ~r_dest;
          w_state_nxt  = ST_RELEASE;
        end else if (r_cnt == CNT_LAST) begin
          w_mov_nxt     = 1'b0;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_RELEASE;
        end else if (r_cnt != 8'hFF) begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      ST_RELEASE: begin
        w_mov_nxt = 1'b0;
        if (!i_moc) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_mov_nxt   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 8'd0;
      r_dest      <= 1'b0;
      r_mov       <= 1'b0;
      r_rw        <= 1'b0;
      r_type      <= 2'b00;
      r_ir_ld     <= 1'b0;
      r_mdr_ld    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_align_err <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_dest      <= w_dest_nxt;
      r_mov       <= w_mov_nxt;
      r_rw        <= w_rw_nxt;
      r_type      <= w_type_nxt;
      r_ir_ld     <= w_ir_ld_nxt;
      r_mdr_ld    <= w_mdr_ld_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_align_err <= w_align_err_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign o_mov       = r_mov;
  assign o_rw        = r_rw;
  assign o_type      = r_type;
  assign o_ir_ld     = r_ir_ld;
  assign o_mdr_ld    = r_mdr_ld;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_align_err = r_align_err;
  assign o_timeout   = r_timeout;
  assign o_state     = r_state;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: a driver issues directed and random
// requests, a reference model queues the expected outcome, a monitor checks strobes.
module tb_mem_access_sequencer;

  localparam int TO = 15;
  localparam logic [2:0] K_DONE  = 3'b100;
  localparam logic [2:0] K_ALIGN = 3'b010;
  localparam logic [2:0] K_TO    = 3'b001;

  logic       i_clk, i_clr, i_req, i_req_rw, i_req_dest, i_moc;
  logic [1:0] i_req_type;
  logic [8:0] i_req_addr;
  logic       o_mov, o_rw, o_ir_ld, o_mdr_ld, o_busy, o_done, o_align_err, o_timeout;
  logic [1:0] o_type, o_state;

  int n_chk = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  mem_access_sequencer #(.TIMEOUT(TO), .ADDR_W(9)) dut (
    .i_clk(i_clk), .i_clr(i_clr), .i_req(i_req), .i_req_rw(i_req_rw),
    .i_req_type(i_req_type), .i_req_dest(i_req_dest), .i_req_addr(i_req_addr),
    .i_moc(i_moc), .o_mov(o_mov), .o_rw(o_rw), .o_type(o_type),
    .o_ir_ld(o_ir_ld), .o_mdr_ld(o_mdr_ld), .o_busy(o_busy), .o_done(o_done),
    .o_align_err(o_align_err), .o_timeout(o_timeout), .o_state(o_state)
  );

  // clock / reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // outcome record: {kind[2:0], ir_ld, mdr_ld, rw, type[1:0], mov_cycles[7:0]}
  function automatic logic [15:0] pack(logic [2:0] kind, logic ir, logic mdr, logic rw,
                                       logic [1:0] ty, logic [7:0] nmov);
    return {kind, ir, mdr, rw, ty, nmov};
  endfunction

  // reference model: moc_delay = edges after acceptance at which MOC is first seen
  function automatic logic [15:0] model(logic rw, logic [1:0] ty, logic dest,
                                        int unsigned addr, int unsigned moc_delay);
    bit bad;
    bad = (ty == 2'd3) || (ty == 2'd1 && addr % 2 != 0) || (ty == 2'd2 && addr % 4 != 0);
    if (bad) return pack(K_ALIGN, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    if (moc_delay <= TO)
      return pack(K_DONE, rw && dest, rw && !dest, rw, ty, 8'(moc_delay));
    return pack(K_TO, 1'b0, 1'b0, rw, ty, 8'(TO));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic poke_req();
    i_req      = 1'b1;
    i_req_rw   = 1'($urandom_range(0, 1));
    i_req_type = 2'($urandom_range(0, 3));
    i_req_dest = 1'($urandom_range(0, 1));
    i_req_addr = 9'($urandom_range(0, 511));
  endtask

  // moc_delay > TO means MOC never rises; hold = edges MOC stays high
  task automatic do_txn(input logic rw, input logic [1:0] ty, input logic dest,
                        input logic [8:0] addr, input int unsigned moc_delay,
                        input int unsigned hold, input bit poke);
    logic [15:0] e;
    e = model(rw, ty, dest, addr, moc_delay);
    i_req = 1'b1; i_req_rw = rw; i_req_type = ty; i_req_dest = dest; i_req_addr = addr;
    exp_q.push_back(e);
    step();
    i_req = 1'b0;
    if (e[15:13] == K_ALIGN) begin
      chk("align_no_busy", {31'd0, o_busy}, 32'd0);
      chk("align_no_mov", {31'd0, o_mov}, 32'd0);
      return;
    end
    if (moc_delay <= TO) begin
      for (int k = 1; k < int'(moc_delay); k++) begin
        if (poke && k == 1) poke_req();
        step();
      end
      i_req = 1'b0;
      i_moc = 1'b1;
      for (int h = 0; h < int'(hold); h++) begin
        if (poke && h == 1) poke_req();
        step();
        chk("busy_in_release", {31'd0, o_busy}, 32'd1);
      end
      i_moc = 1'b0;
      i_req = 1'b0;
    end else begin
      for (int k = 1; k < TO; k++) begin
        if (poke && k == 1) poke_req();
        step();
      end
      i_req = 1'b0;
      step();
      chk("busy_after_timeout", {31'd0, o_busy}, 32'd1);
    end
    step();
    chk("busy_falls", {31'd0, o_busy}, 32'd0);
  endtask

  // monitor: pops one expected outcome per strobe cycle
  logic [7:0]  mov_cnt = 8'd0;
  logic        mov_rw  = 1'b0;
  logic [1:0]  mov_ty  = 2'd0;
  logic [15:0] act_w, exp_w;

  always @(negedge i_clk) begin
    if (i_clr) begin
      mov_cnt = 8'd0;
    end else begin
      if (o_mov) begin
        if (mov_cnt == 8'd0) begin
          mov_rw = o_rw;
          mov_ty = o_type;
        end else begin
          chk("mov_stable", {29'd0, o_rw, o_type}, {29'd0, mov_rw, mov_ty});
        end
        chk("busy_with_mov", {31'd0, o_busy}, 32'd1);
        mov_cnt = mov_cnt + 8'd1;
      end
      if (o_done || o_align_err || o_timeout || o_ir_ld || o_mdr_ld) begin
        act_w = pack({o_done, o_align_err, o_timeout}, o_ir_ld, o_mdr_ld,
                     (mov_cnt != 0) ? mov_rw : 1'b0, (mov_cnt != 0) ? mov_ty : 2'd0, mov_cnt);
        n_chk++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_strobe: got %0h expected none", act_w);
        end else begin
          exp_w = exp_q.pop_front();
          if (act_w !== exp_w) begin
            n_err++;
            $display("FAIL outcome: got %0h expected %0h", act_w, exp_w);
          end
        end
        mov_cnt = 8'd0;
      end
    end
  end

  initial begin
    i_clr = 1'b1; i_req = 1'b0; i_req_rw = 1'b0; i_req_type = 2'd0;
    i_req_dest = 1'b0; i_req_addr = 9'd0; i_moc = 1'b0;
    step(); step(); step();
    chk("reset_outputs", {22'd0, o_mov, o_rw, o_type, o_ir_ld, o_mdr_ld, o_busy, o_done,
                          o_align_err, o_timeout}, 32'd0);
    chk("reset_state", {30'd0, o_state}, 32'd0);
    i_clr = 1'b0;
    step();

    // word fetch, MOC after 3 cycles held 2
    do_txn(1'b1, 2'd2, 1'b1, 9'h004, 3, 2, 1'b0);
    // misaligned halfword store and illegal type
    do_txn(1'b0, 2'd1, 1'b0, 9'h003, 1, 1, 1'b0);
    do_txn(1'b1, 2'd3, 1'b0, 9'h000, 1, 1, 1'b0);
    // byte load with no MOC -> timeout
    do_txn(1'b1, 2'd0, 1'b0, 9'h1FF, TO + 5, 1, 1'b0);
    // requests during ACCESS ignored, then a word write re-presented
    do_txn(1'b1, 2'd0, 1'b0, 9'h010, 6, 1, 1'b1);
    do_txn(1'b0, 2'd2, 1'b0, 9'h008, 2, 1, 1'b0);
    // MOC stuck high 6 cycles with a request poked during RELEASE
    do_txn(1'b1, 2'd1, 1'b0, 9'h002, 1, 6, 1'b1);
    // MOC on the last allowed edge still completes
    do_txn(1'b1, 2'd2, 1'b1, 9'h100, TO, 1, 1'b0);
    // MOC in IDLE ignored
    i_moc = 1'b1; step(); i_moc = 1'b0; step();

    // reset two cycles into ACCESS
    i_req = 1'b1; i_req_rw = 1'b1; i_req_type = 2'd2; i_req_dest = 1'b1; i_req_addr = 9'h00C;
    step();
    i_req = 1'b0;
    step(); step();
    i_clr = 1'b1;
    step();
    i_clr = 1'b0;
    chk("midreset_outputs", {22'd0, o_mov, o_rw, o_type, o_ir_ld, o_mdr_ld, o_busy, o_done,
                             o_align_err, o_timeout}, 32'd0);
    chk("midreset_state", {30'd0, o_state}, 32'd0);
    i_moc = 1'b1; step(); i_moc = 1'b0; step(); step();
    do_txn(1'b1, 2'd0, 1'b0, 9'h0A1, 2, 1, 1'b0);

    // randomized traffic
    for (int t = 0; t < 200; t++) begin
      int unsigned d;
      d = ($urandom_range(0, 5) == 0) ? TO + 1 + $urandom_range(0, 3) : $urandom_range(1, TO);
      do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             9'($urandom_range(0, 511)), d, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        i_moc = 1'($urandom_range(0, 1));
        step();
        i_moc = 1'b0;
      end
    end

    for (int w = 0; w < 20 && exp_q.size() != 0; w++) step();
    step(); step();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
